systolic_tile_feeder: RTL and testbench

- Upstream sequencer for systolic_array_cluster.
- Accepts one tile job over a valid/ready handshake and clears the target array's accumulators if requested.
- Loads ARRAY_SIZE weight rows, then streams K activation vectors with diagonal (per-lane) skew while compute is enabled.
- Drains the pipeline, waits for the cluster ready signal, then pulses done.
- Sole driver of the cluster's control and data inputs.

---
 rtl/systolic_pkg.sv | 40 ++++
 rtl/systolic_skew_line.sv | 39 +++
 rtl/systolic_tile_feeder.sv | 149 ++++++++++++++
 tb/tb_systolic_tile_feeder.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic tile feeder and its skew lines.
package systolic_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CLEAR    = 3'd1;
  localparam logic [2:0] ST_LOAD_W   = 3'd2;
  localparam logic [2:0] ST_STREAM   = 3'd3;
  localparam logic [2:0] ST_DRAIN    = 3'd4;
  localparam logic [2:0] ST_WAIT_RDY = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    CLEAR    = ST_CLEAR,
    LOAD_W   = ST_LOAD_W,
    STREAM   = ST_STREAM,
    DRAIN    = ST_DRAIN,
    WAIT_RDY = ST_WAIT_RDY,
    DONE     = ST_DONE
  } feeder_state_t;

  // Cycles needed to flush the last skewed vector through an N x N array.
  function automatic int drain_cycles(input int array_size);
    return 2 * array_size - 2;
  endfunction

  function automatic int sel_width(input int num_arrays);
    return (num_arrays > 1) ? $clog2(num_arrays) : 1;
  endfunction

  function automatic int beat_width(input int array_size);
    return $clog2(array_size) + 1;
  endfunction

  localparam int DEFAULT_ARRAY_SIZE = 8;
  localparam int DEFAULT_NUM_ARRAYS = 8;
  localparam int DEFAULT_SEL_W      = sel_width(DEFAULT_NUM_ARRAYS);
  localparam int DEFAULT_BEAT_W     = beat_width(DEFAULT_ARRAY_SIZE);

endpackage

// File: rtl/systolic_skew_line.sv
// Per-lane delay line: lane LANE is delayed by LANE shift-enabled cycles; lane 0 is a wire.
module systolic_skew_line #(
  parameter int DATA_BITS = 16,
  parameter int LANE      = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 shift_en,
  input  logic                 flush,
  input  logic [DATA_BITS-1:0] din,
  output logic [DATA_BITS-1:0] dout
);

  generate
    if (LANE == 0) begin : g_bypass
      logic unused_ctrl;
      assign unused_ctrl = &{1'b0, clk, reset, shift_en, flush};
      assign dout = din;
    end else begin : g_delay
      logic [LANE-1:0][DATA_BITS-1:0] pipe;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          pipe <= '0;
        end else if (flush) begin
          pipe <= '0;
        end else if (shift_en) begin
          pipe[0] <= din;
          for (int j = 1; j < LANE; j++) begin
            pipe[j] <= pipe[j-1];
          end
        end
      end

      assign dout = pipe[LANE-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_tile_feeder.sv
// Tile job sequencer for systolic_array_cluster: clear, weight load, skewed streaming, drain, done.
// Optional bubble counter enabled by defining FEEDER_STALL_CNT_EN.
module systolic_tile_feeder
  import systolic_pkg::*;
#(
  parameter  int DATA_BITS  = 16,
  parameter  int ARRAY_SIZE = DEFAULT_ARRAY_SIZE,
  parameter  int NUM_ARRAYS = DEFAULT_NUM_ARRAYS,
  parameter  int K_BITS     = 10,
  localparam int SEL_W      = sel_width(NUM_ARRAYS)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 job_valid,
  output logic                                 job_ready,
  input  logic [SEL_W-1:0]                     job_array,
  input  logic [K_BITS-1:0]                    job_k_len,
  input  logic                                 job_accumulate,
  input  logic                                 job_broadcast,
  input  logic                                 w_valid,
  output logic                                 w_ready,
  input  logic [ARRAY_SIZE-1:0][DATA_BITS-1:0] w_row,
  input  logic                                 a_valid,
  output logic                                 a_ready,
  input  logic [ARRAY_SIZE-1:0][DATA_BITS-1:0] a_vec,
  output logic [SEL_W-1:0]                     array_select,
  output logic                                 broadcast_mode,
  output logic                                 clear_acc,
  output logic                                 load_weights,
  output logic                                 compute_enable,
  output logic [ARRAY_SIZE-1:0][DATA_BITS-1:0] a_inputs,
  output logic [ARRAY_SIZE-1:0][DATA_BITS-1:0] b_inputs,
  input  logic                                 cl_ready,
  output logic                                 done,
  output logic [31:0]                          stall_cycles
);

  localparam int                BEAT_W     = beat_width(ARRAY_SIZE);
  localparam logic [BEAT_W-1:0] BEAT_ONE   = BEAT_W'(1);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(ARRAY_SIZE - 1);
  localparam logic [BEAT_W-1:0] LAST_DRAIN = BEAT_W'(drain_cycles(ARRAY_SIZE) - 1);
  localparam logic [K_BITS-1:0] K_ONE      = K_BITS'(1);

  feeder_state_t state, state_nxt;
  logic [BEAT_W-1:0] beat_cnt;
  logic [K_BITS-1:0] k_len, k_cnt;
  logic              started;
  logic              job_fire, w_fire, a_fire, streaming;
  logic [ARRAY_SIZE-1:0][DATA_BITS-1:0] skew_in, skew_out;

  // started keeps job_ready low while reset is held and for the release edge.
  assign job_ready      = started && (state == IDLE);
  assign job_fire       = job_valid && job_ready;
  assign w_ready        = (state == LOAD_W);
  assign w_fire         = w_valid && w_ready;
  assign a_ready        = (state == STREAM);
  assign a_fire         = a_valid && a_ready;
  assign streaming      = (state == STREAM) || (state == DRAIN);
  assign clear_acc      = (state == CLEAR);
  assign load_weights   = w_fire;
  assign compute_enable = streaming;
  assign done           = (state == DONE);
  assign b_inputs       = w_fire ? w_row : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (job_fire) state_nxt = job_accumulate ? LOAD_W : CLEAR;
      CLEAR:    state_nxt = LOAD_W;
      LOAD_W:   if (w_fire && (beat_cnt == LAST_BEAT))
                  state_nxt = (k_len == '0) ? WAIT_RDY : STREAM;
      STREAM:   if (a_fire && (k_cnt == k_len - K_ONE)) state_nxt = DRAIN;
      DRAIN:    if (beat_cnt == LAST_DRAIN) state_nxt = WAIT_RDY;
      WAIT_RDY: if (cl_ready) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // beat_cnt is shared: weight beats in LOAD_W, then drain cycles in DRAIN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      started        <= 1'b0;
      beat_cnt       <= '0;
      k_cnt          <= '0;
      k_len          <= '0;
      array_select   <= '0;
      broadcast_mode <= 1'b0;
    end else begin
      started <= 1'b1;
      state   <= state_nxt;
      if (job_fire) begin
        array_select   <= job_array;
        broadcast_mode <= job_broadcast;
        k_len          <= job_k_len;
      end
      case (state)
        LOAD_W: if (w_fire) beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BEAT_ONE;
        STREAM: if (a_fire) k_cnt <= k_cnt + K_ONE;
        DRAIN:  beat_cnt <= beat_cnt + BEAT_ONE;
        default: begin
          beat_cnt <= '0;
          k_cnt    <= '0;
        end
      endcase
    end
  end

  // Bubbles and drain cycles shift zeros into every lane.
  assign skew_in = a_fire ? a_vec : '0;

  generate
    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
      systolic_skew_line #(
        .DATA_BITS (DATA_BITS),
        .LANE      (i)
      ) u_skew (
        .clk      (clk),
        .reset    (reset),
        .shift_en (streaming),
        .flush    (state == DONE),
        .din      (skew_in[i]),
        .dout     (skew_out[i])
      );
      assign a_inputs[i] = streaming ? skew_out[i] : '0;
    end
  endgenerate

`ifdef FEEDER_STALL_CNT_EN
  logic        stall_evt;
  logic [31:0] stall_cnt;

  assign stall_evt = ((state == STREAM) && !a_valid) || ((state == LOAD_W) && !w_valid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall_evt && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_tile_feeder.sv
// Directed bench for systolic_tile_feeder: clear/load/stream/drain sequencing, skew, bubbles, reset.
module tb_systolic_tile_feeder;

  localparam int DB = 16;
  localparam int AS = 8;
  localparam int NA = 8;
  localparam int KB = 10;

  typedef logic [AS-1:0][DB-1:0] vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [2:0]    job_array = '0;
  logic [KB-1:0] job_k_len = '0;
  logic          job_accumulate = 1'b0;
  logic          job_broadcast = 1'b0;
  logic          w_valid = 1'b0;
  logic          w_ready;
  vec_t          w_row = '0;
  logic          a_valid = 1'b0;
  logic          a_ready;
  vec_t          a_vec = '0;
  logic [2:0]    array_select;
  logic          broadcast_mode, clear_acc, load_weights, compute_enable;
  vec_t          a_inputs, b_inputs;
  logic          cl_ready = 1'b1;
  logic          done;
  logic [31:0]   stall_cycles;

  int n_vectors = 0;
  int n_miscompares = 0;
  int cur_arr = 0;
  int drain_len;
  int stall_base;
  vec_t exp_vec;
  logic [7:0] bubble_pat;

  always #5 clk = ~clk;

  systolic_tile_feeder #(
    .DATA_BITS  (DB),
    .ARRAY_SIZE (AS),
    .NUM_ARRAYS (NA),
    .K_BITS     (KB)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .job_valid      (job_valid),
    .job_ready      (job_ready),
    .job_array      (job_array),
    .job_k_len      (job_k_len),
    .job_accumulate (job_accumulate),
    .job_broadcast  (job_broadcast),
    .w_valid        (w_valid),
    .w_ready        (w_ready),
    .w_row          (w_row),
    .a_valid        (a_valid),
    .a_ready        (a_ready),
    .a_vec          (a_vec),
    .array_select   (array_select),
    .broadcast_mode (broadcast_mode),
    .clear_acc      (clear_acc),
    .load_weights   (load_weights),
    .compute_enable (compute_enable),
    .a_inputs       (a_inputs),
    .b_inputs       (b_inputs),
    .cl_ready       (cl_ready),
    .done           (done),
    .stall_cycles   (stall_cycles)
  );

  task automatic check_bit(input string tag, input logic observed, input logic expected);
    n_vectors++;
    assert (observed === expected) else begin
      n_miscompares++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic check_int(input string tag, input int observed, input int expected);
    n_vectors++;
    assert (observed === expected) else begin
      n_miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_vec(input string tag, input vec_t observed, input vec_t expected);
    n_vectors++;
    assert (observed === expected) else begin
      n_miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic vec_t make_row(input logic [15:0] seed, input int beat);
    vec_t r;
    for (int l = 0; l < AS; l++) r[l] = seed + 16'(beat * 16 + l);
    return r;
  endfunction

  // Offers one job; returns just after the first LOAD_W negedge.
  task automatic offer_job(input int arr, input int k, input logic acc, input logic bc);
    job_valid = 1'b1; job_array = 3'(arr); job_k_len = KB'(k);
    job_accumulate = acc; job_broadcast = bc; cur_arr = arr;
    #1;
    check_bit("job_ready_idle", job_ready, 1'b1);
    @(negedge clk);
    job_valid = 1'b0;
    #1;
    check_int("array_select_latched", int'(array_select), arr);
    check_bit("broadcast_mode_latched", broadcast_mode, bc);
    check_bit("job_ready_busy", job_ready, 1'b0);
    check_bit("clear_acc_first", clear_acc, !acc);
    if (!acc) begin
      @(negedge clk);
      #1;
    end
    check_bit("clear_acc_once", clear_acc, 1'b0);
    check_bit("w_ready_load", w_ready, 1'b1);
  endtask

  task automatic load_beats(input int n, input logic [15:0] seed, input int gap_at);
    vec_t row;
    for (int b = 0; b < n; b++) begin
      if (b == gap_at) begin
        w_valid = 1'b0; w_row = make_row(seed, 99);
        #1;
        check_bit("gap_no_load", load_weights, 1'b0);
        check_vec("gap_b_zero", b_inputs, '0);
        @(negedge clk);
      end
      row = make_row(seed, b);
      w_valid = 1'b1; w_row = row;
      #1;
      check_bit("w_ready", w_ready, 1'b1);
      check_bit("load_weights", load_weights, 1'b1);
      check_vec("b_inputs", b_inputs, row);
      check_bit("a_ready_in_load", a_ready, 1'b0);
      @(negedge clk);
    end
    w_valid = 1'b0; w_row = '0;
  endtask

  task automatic stream_beats(input int k, input logic [15:0] seed);
    vec_t v;
    for (int b = 0; b < k; b++) begin
      v = make_row(seed, b);
      a_valid = 1'b1; a_vec = v;
      #1;
      check_bit("a_ready", a_ready, 1'b1);
      check_bit("w_ready_in_stream", w_ready, 1'b0);
      check_bit("compute_enable_stream", compute_enable, 1'b1);
      check_int("lane0_passthru", int'(a_inputs[0]), int'(v[0]));
      check_int("array_select_held", int'(array_select), cur_arr);
      @(negedge clk);
    end
    a_valid = 1'b0; a_vec = '0;
  endtask

  // Counts DRAIN cycles; leaves 1 time unit into the first WAIT_RDY cycle.
  task automatic drain_check();
    drain_len = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!compute_enable) break;
      drain_len++;
      @(negedge clk);
    end
    check_int("drain_len", drain_len, 14);
    check_bit("wait_no_done", done, 1'b0);
    check_vec("wait_a_zero", a_inputs, '0);
  endtask

  task automatic expect_done();
    @(negedge clk);
    #1;
    check_bit("done_pulse", done, 1'b1);
    check_bit("done_job_ready", job_ready, 1'b0);
    check_int("done_array_select", int'(array_select), cur_arr);
    @(negedge clk);
    #1;
    check_bit("done_single", done, 1'b0);
    check_bit("idle_job_ready", job_ready, 1'b1);
  endtask

  initial begin
    // Reset state
    #12;
    check_bit("rst_job_ready", job_ready, 1'b0);
    check_bit("rst_clear_acc", clear_acc, 1'b0);
    check_bit("rst_compute", compute_enable, 1'b0);
    check_int("rst_stall", int'(stall_cycles), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_bit("post_rst_job_ready", job_ready, 1'b1);

    // Job 1: array 3, clear, k=4
    offer_job(3, 4, 1'b0, 1'b0);
    load_beats(8, 16'h1000, -1);
    stream_beats(4, 16'h2000);
    drain_check();
    expect_done();

    // Job 2: single all-0x0100 vector, lanes must emerge diagonally
    offer_job(5, 1, 1'b1, 1'b1);
    load_beats(8, 16'h3000, -1);
    a_valid = 1'b1;
    for (int l = 0; l < AS; l++) a_vec[l] = 16'h0100;
    #1;
    exp_vec = '0; exp_vec[0] = 16'h0100;
    check_vec("skew_d0", a_inputs, exp_vec);
    check_bit("skew_ce_d0", compute_enable, 1'b1);
    @(negedge clk);
    a_valid = 1'b0; a_vec = '0;
    #1;
    for (int d = 1; d <= 15; d++) begin
      exp_vec = '0;
      if (d < AS) exp_vec[d] = 16'h0100;
      check_vec($sformatf("skew_d%0d", d), a_inputs, exp_vec);
      check_bit($sformatf("skew_ce_d%0d", d), compute_enable, d <= 14);
      if (d < 15) begin
        @(negedge clk);
        #1;
      end
    end
    expect_done();

    // Job 3: k=5 with three bubbles mid-stream
    stall_base = int'(stall_cycles);
    offer_job(1, 5, 1'b1, 1'b0);
    load_beats(8, 16'h4000, -1);
    bubble_pat = 8'b1110_0011;
    for (int i = 0; i < 8; i++) begin
      exp_vec = make_row(16'h5000, i);
      a_valid = bubble_pat[i]; a_vec = exp_vec;
      #1;
      check_bit("bubble_a_ready", a_ready, 1'b1);
      check_bit("bubble_ce", compute_enable, 1'b1);
      check_int("bubble_lane0", int'(a_inputs[0]), bubble_pat[i] ? int'(exp_vec[0]) : 0);
      @(negedge clk);
    end
    a_valid = 1'b0; a_vec = '0;
    #1;
    check_bit("stream_exit_after_5", a_ready, 1'b0);
    drain_check();
    expect_done();
`ifdef FEEDER_STALL_CNT_EN
    check_int("stall_bubbles", int'(stall_cycles) - stall_base, 3);
`else
    check_int("stall_tied_zero", int'(stall_cycles), 0);
`endif

    // Job 4: k=0, accumulate, one w_valid gap
    stall_base = int'(stall_cycles);
    offer_job(6, 0, 1'b1, 1'b0);
    load_beats(8, 16'h6000, 3);
    #1;
    check_bit("k0_no_compute", compute_enable, 1'b0);
    check_bit("k0_no_a_ready", a_ready, 1'b0);
    check_bit("k0_no_done_yet", done, 1'b0);
    expect_done();
`ifdef FEEDER_STALL_CNT_EN
    check_int("stall_w_gap", int'(stall_cycles) - stall_base, 1);
`else
    check_int("stall_tied_zero_w", int'(stall_cycles), 0);
`endif

    // Job 5: cl_ready held low for 10 cycles after drain
    cl_ready = 1'b0;
    offer_job(2, 1, 1'b1, 1'b0);
    load_beats(8, 16'h7000, -1);
    stream_beats(1, 16'h7100);
    drain_check();
    for (int i = 0; i < 10; i++) begin
      check_bit("wait_done_low", done, 1'b0);
      check_bit("wait_job_ready_low", job_ready, 1'b0);
      @(negedge clk);
      #1;
    end
    cl_ready = 1'b1;
    #1;
    check_bit("cl_rise_no_done", done, 1'b0);
    expect_done();

    // Job 6: reset after 4 of 8 weight beats, then a clean job
    offer_job(2, 2, 1'b1, 1'b1);
    load_beats(4, 16'h8000, -1);
    w_valid = 1'b1; w_row = make_row(16'h8000, 4);
    #1;
    check_bit("pre_rst_load", load_weights, 1'b1);
    reset = 1'b0;
    #1;
    check_bit("async_w_ready", w_ready, 1'b0);
    check_bit("async_load", load_weights, 1'b0);
    check_vec("async_b_zero", b_inputs, '0);
    check_int("async_array_select", int'(array_select), 0);
    check_bit("async_broadcast", broadcast_mode, 1'b0);
    check_bit("async_job_ready", job_ready, 1'b0);
    check_bit("async_clear_acc", clear_acc, 1'b0);
    w_valid = 1'b0; w_row = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_bit("rerst_job_ready", job_ready, 1'b1);
    check_int("rerst_stall", int'(stall_cycles), 0);
    offer_job(4, 2, 1'b0, 1'b0);
    load_beats(8, 16'h9000, -1);
    stream_beats(2, 16'hA000);
    drain_check();
    expect_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
